wb_b3_burst_master: RTL and testbench
=====================================

# wb_b3_burst_master

Wishbone B3 registered-feedback bus initiator: accepts one read or write command from a local client and executes it on the bus as a classic single cycle or a linear/wrapping incrementing burst. It is the initiator-side counterpart of the team's B3 burst-capable SRAM responder and drives that responder (or any B3 slave) directly. Write data streams in through a valid/ready port; read data streams out as registered single-cycle pulses. Completion and error status are reported per command.

## Interface
- aw, 16: byte-address width of wb_adr_o and cmd_adr.
- dw, 32: data width; fixed at 32 (4 byte lanes).
- TIMEOUT, 255: wait cycles with stb high and no response before the command is aborted; range 1..255.

- wb_clk_i  in  1  clock; all logic is on the rising edge.
- wb_rst_i  in  1  reset; asynchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_adr  in  aw  start byte address; bits [1:0] are ignored and driven as 0.
- cmd_len  in  5  beat count, 1..16.
- cmd_bte  in  2  00 linear, 01 wrap-4, 10 wrap-8, 11 wrap-16.
- cmd_sel  in  4  byte lanes for every write beat; reads always use 4'hf.
- wr_valid / wr_ready / wr_data  in / out / in  1/1/dw  write-data stream, one word per beat.
- rd_valid / rd_data  out / out  1/dw  read beat, registered; no backpressure.
- done  out  1  one-cycle pulse when a command ends.
- err  out  1  valid with done; 1 = aborted or rejected.
- wb_adr_o, wb_bte_o, wb_cti_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_dat_o  out  aw/2/3/1/1/1/4/dw  Wishbone master outputs.
- wb_ack_i, wb_err_i, wb_rty_i, wb_dat_i  in  1/1/1/dw  Wishbone responses.

## Operation
- States: IDLE, BUS.
- IDLE: cmd_ready=1, wb_cyc_o=0. On cmd_valid:
  - Reject with done=1, err=1 the next cycle and no bus activity if cmd_len is 0 or greater than 16.
  - Also reject if cmd_bte≠00 and cmd_len≠wrap size (4/8/16).
  - Otherwise latch the command, load the beat counter with cmd_len, and go to BUS.
- BUS: wb_cyc_o=1. wb_we_o, wb_bte_o and wb_sel_o are held for the whole command.
  - Read: wb_stb_o=1 continuously.
  - Write: wb_stb_o=wd_full, where wd_full is a 1-entry write-data holding register that drives wb_dat_o.
- wr_ready = write command active & (beats still to fetch > 0) & (!wd_full | (wb_ack_i & wb_stb_o)). This is a combinational path from wb_ack_i, which is permitted.
- CTI:
  - cmd_len=1: 000 (classic).
  - Otherwise: 010 on every beat except the last, which is 111.
- Beat complete = wb_ack_i & wb_stb_o.
  - Decrement the remaining-beat count.
  - Advance wb_adr_o in the same edge.
  - Read: capture wb_dat_i into rd_data and pulse rd_valid next cycle.
- Address advance, word = byte address[aw-1:2]:
  - Linear: +4 modulo 2^aw.
  - Wrap-4: only bits [3:2] increment; bits [aw-1:4] are held.
  - Wrap-8: only bits [4:2] increment.
  - Wrap-16: only bits [5:2] increment.
- Last beat acked: go to IDLE, deassert cyc/stb, pulse done with err=0.
- wb_err_i or wb_rty_i while stb is high (retry is not supported):
  - Abort, go to IDLE, pulse done with err=1.
  - Remaining write words are not consumed; the client flushes them.
- Timeout: an 8-bit counter counts cycles with stb=1 & !ack & !err & !rty and clears on any beat completion.
  - Reaching TIMEOUT aborts as for wb_err_i.
  - The counter does not run while stb is low waiting on wr_valid.

## Timing
- Reset (asynchronous, mid-command included): state returns to IDLE immediately.
  - Zero outputs: wb_cyc_o, wb_stb_o, wb_we_o, rd_valid, done, err, wb_adr_o, wb_cti_o, wb_bte_o, wb_sel_o, wb_dat_o, rd_data.
  - cmd_ready=1 once reset is released.
- Command accepted at edge T: wb_cyc_o/wb_adr_o are valid from T+1.
  - Read: stb is high at T+1.
  - Write: stb goes high the cycle after the first wr_valid&wr_ready.
- Against a registered-ack slave the first ack lands at T+2, then one beat per cycle while stb stays high.
- rd_valid appears 1 cycle after each ack.
- done/err appear 1 cycle after the final ack or the abort. cmd_ready is high in that same cycle, so back-to-back commands have at least one cycle with cyc low.
- wb_cti_o changes to 111 in the cycle after the second-to-last beat's ack.
- wb_stb_o drops in the same edge as the last ack.
- A write stall (wr_valid low) deasserts stb but keeps cyc and cti unchanged.

## Test plan
- Single read, cmd_adr=0x0010, len=1, bte=00 -> one cycle with cti=000, adr=0x0010; rd_valid once; done at T+3, err=0.
- Linear 8-beat write from 0x0100, data 0x11..0x88, sel=f -> adr 0x0100..0x011C step 4; cti 010×7 then 111; readback through the SRAM slave matches.
- Wrap-4 read from 0x0038 -> adr sequence 0x0038, 0x003C, 0x0030, 0x0034; 4 rd_valid pulses in order.
- Rejects -> len=0, and len=5 with bte=01 -> done+err=1 the cycle after accept, wb_cyc_o never asserted.
- Faults -> wb_err_i on beat 3 of 8 -> cyc drops next cycle, done+err=1, 2 rd_valid only.
  - Slave never acks -> abort after 255 stb cycles with err=1.
- Write with wr_valid gaps on beats 2 and 5 plus reset asserted mid-burst -> stb low during gaps with adr/cti held and no timeout; on reset, all outputs 0 asynchronously and cmd_ready=1 after release.

Source files
------------

// File: rtl/wb_b3_burst_master.sv
// Wishbone B3 registered-feedback initiator: one client command becomes a classic
// cycle or a linear/wrapping incrementing burst, with write-data and read-data streams.
module wb_b3_burst_master #(
    parameter int aw      = 16,
    parameter int dw      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_we,
    input  logic [aw-1:0] cmd_adr,
    input  logic [4:0]    cmd_len,
    input  logic [1:0]    cmd_bte,
    input  logic [3:0]    cmd_sel,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [dw-1:0] wr_data,
    output logic          rd_valid,
    output logic [dw-1:0] rd_data,
    output logic          done,
    output logic          err,
    output logic [aw-1:0] wb_adr_o,
    output logic [1:0]    wb_bte_o,
    output logic [2:0]    wb_cti_o,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    output logic          wb_we_o,
    output logic [3:0]    wb_sel_o,
    output logic [dw-1:0] wb_dat_o,
    input  logic          wb_ack_i,
    input  logic          wb_err_i,
    input  logic          wb_rty_i,
    input  logic [dw-1:0] wb_dat_i
);

    typedef enum logic {IDLE = 1'b0, BUS = 1'b1} state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t        state_q;
    logic          cyc_q, we_q, wd_full_q, rd_valid_q, done_q, err_q;
    logic [aw-1:0] adr_q;
    logic [1:0]    bte_q;
    logic [2:0]    cti_q;
    logic [3:0]    sel_q;
    logic [4:0]    cnt_q, fetch_q;
    logic [7:0]    tmo_q;
    logic [dw-1:0] wd_q, rd_data_q;

    logic [4:0]    cmd_wrap_len;
    logic          cmd_bad, beat, fault, wr_fire;
    logic [aw-3:0] wrap_mask, word_inc, word_next;
    logic          adr_lsb_unused;

    assign adr_lsb_unused = ^cmd_adr[1:0];

    always_comb begin
        cmd_wrap_len = 5'd0;
        case (cmd_bte)
            2'b01:   cmd_wrap_len = 5'd4;
            2'b10:   cmd_wrap_len = 5'd8;
            2'b11:   cmd_wrap_len = 5'd16;
            default: cmd_wrap_len = 5'd0;
        endcase
        cmd_bad = (cmd_len == 5'd0) || (cmd_len > 5'd16) ||
                  ((cmd_bte != 2'b00) && (cmd_len != cmd_wrap_len));
    end

    // Wrapping bursts only advance the low word-address bits inside the wrap window.
    always_comb begin
        wrap_mask = '1;
        case (bte_q)
            2'b01:   wrap_mask = (aw-2)'(3);
            2'b10:   wrap_mask = (aw-2)'(7);
            2'b11:   wrap_mask = (aw-2)'(15);
            default: wrap_mask = '1;
        endcase
        word_inc  = adr_q[aw-1:2] + (aw-2)'(1);
        word_next = (adr_q[aw-1:2] & ~wrap_mask) | (word_inc & wrap_mask);
    end

    assign wb_stb_o = cyc_q & (~we_q | wd_full_q);
    assign beat     = wb_ack_i & wb_stb_o;
    assign fault    = wb_stb_o & (wb_err_i | wb_rty_i | (~wb_ack_i & (tmo_q == TMO_LAST)));
    // The holding register can refill in the same cycle its word is acked.
    assign wr_ready = cyc_q & we_q & (fetch_q != 5'd0) & (~wd_full_q | beat);
    assign wr_fire  = wr_valid & wr_ready;

    assign cmd_ready = (state_q == IDLE);
    assign wb_cyc_o  = cyc_q;
    assign wb_we_o   = we_q;
    assign wb_adr_o  = adr_q;
    assign wb_bte_o  = bte_q;
    assign wb_cti_o  = cti_q;
    assign wb_sel_o  = sel_q;
    assign wb_dat_o  = wd_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign done      = done_q;
    assign err       = err_q;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= IDLE;
            cyc_q      <= 1'b0;
            we_q       <= 1'b0;
            wd_full_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            adr_q      <= '0;
            bte_q      <= 2'b00;
            cti_q      <= 3'b000;
            sel_q      <= 4'h0;
            cnt_q      <= 5'd0;
            fetch_q    <= 5'd0;
            tmo_q      <= 8'd0;
            wd_q       <= '0;
            rd_data_q  <= '0;
        end else begin
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_bad) begin
                            done_q <= 1'b1;
                            err_q  <= 1'b1;
                        end else begin
                            state_q   <= BUS;
                            cyc_q     <= 1'b1;
                            we_q      <= cmd_we;
                            adr_q     <= {cmd_adr[aw-1:2], 2'b00};
                            bte_q     <= cmd_bte;
                            sel_q     <= cmd_we ? cmd_sel : 4'hf;
                            cti_q     <= (cmd_len == 5'd1) ? 3'b000 : 3'b010;
                            cnt_q     <= cmd_len;
                            fetch_q   <= cmd_we ? cmd_len : 5'd0;
                            tmo_q     <= 8'd0;
                            wd_full_q <= 1'b0;
                        end
                    end
                end
                BUS: begin
                    if (fault) begin
                        state_q   <= IDLE;
                        cyc_q     <= 1'b0;
                        cti_q     <= 3'b000;
                        wd_full_q <= 1'b0;
                        done_q    <= 1'b1;
                        err_q     <= 1'b1;
                    end else begin
                        if (wr_fire) begin
                            wd_q      <= wr_data;
                            fetch_q   <= fetch_q - 5'd1;
                            wd_full_q <= 1'b1;
                        end else if (beat) begin
                            wd_full_q <= 1'b0;
                        end
                        if (beat) begin
                            tmo_q <= 8'd0;
                            cnt_q <= cnt_q - 5'd1;
                            adr_q <= {word_next, 2'b00};
                            if (!we_q) begin
                                rd_valid_q <= 1'b1;
                                rd_data_q  <= wb_dat_i;
                            end
                            if (cnt_q == 5'd1) begin
                                state_q   <= IDLE;
                                cyc_q     <= 1'b0;
                                cti_q     <= 3'b000;
                                wd_full_q <= 1'b0;
                                done_q    <= 1'b1;
                            end else if (cnt_q == 5'd2) begin
                                cti_q <= 3'b111;
                            end
                        end else if (wb_stb_o) begin
                            tmo_q <= tmo_q + 8'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_b3_burst_master.sv
// Directed and randomized bench for wb_b3_burst_master against a registered-ack
// memory slave, with addresses and data predicted from the burst rules.
module tb_wb_b3_burst_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
    logic [15:0] cmd_adr = '0;
    logic [4:0]  cmd_len = '0;
    logic [1:0]  cmd_bte = '0;
    logic [3:0]  cmd_sel = '0;
    logic        wr_valid = 1'b0, wr_ready;
    logic [31:0] wr_data = '0;
    logic        rd_valid, done, err;
    logic [31:0] rd_data;
    logic [15:0] wb_adr_o;
    logic [1:0]  wb_bte_o;
    logic [2:0]  wb_cti_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_o, wb_dat_i;
    logic        wb_ack_i, wb_err_i, wb_rty_i;

    always #5 clk = ~clk;

    wb_b3_burst_master dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_adr(cmd_adr),
        .cmd_len(cmd_len), .cmd_bte(cmd_bte), .cmd_sel(cmd_sel),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .err(err),
        .wb_adr_o(wb_adr_o), .wb_bte_o(wb_bte_o), .wb_cti_o(wb_cti_o), .wb_cyc_o(wb_cyc_o),
        .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i), .wb_dat_i(wb_dat_i)
    );

    function automatic logic [31:0] mem_init(input int i);
        return (32'(i) * 32'h9e37_79b1) ^ 32'h0bad_f00d;
    endfunction

    // Slave: registered ack, continuous acks while a burst is open, combinational read data.
    logic [31:0] s_mem [0:16383];
    logic [31:0] ref_mem [0:16383];
    logic        s_resp_q;
    int          s_beats;
    int          err_at = 0;
    bit          nack = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            s_resp_q <= 1'b0;
            s_beats  <= 0;
        end else begin
            s_resp_q <= wb_cyc_o & wb_stb_o & !nack &
                        !(s_resp_q & (wb_cti_o == 3'b000 || wb_cti_o == 3'b111));
            if (!wb_cyc_o) s_beats <= 0;
            else if (wb_ack_i & wb_stb_o) s_beats <= s_beats + 1;
        end
    end

    assign wb_err_i = s_resp_q & (err_at != 0) & (s_beats == err_at - 1);
    assign wb_ack_i = s_resp_q & !wb_err_i;
    assign wb_rty_i = 1'b0;
    assign wb_dat_i = s_mem[wb_adr_o[15:2]];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16384; i++) s_mem[i] <= mem_init(i);
        end else if (wb_cyc_o & wb_stb_o & wb_we_o & wb_ack_i) begin
            for (int b = 0; b < 4; b++)
                if (wb_sel_o[b]) s_mem[wb_adr_o[15:2]][8*b +: 8] <= wb_dat_o[8*b +: 8];
        end
    end

    // Monitor, sampled on the falling edge; cleared on request from the stimulus.
    int          clr_req = 0, clr_ack = 0, cyc_n = 0;
    logic [15:0] q_adr [$];
    logic [2:0]  q_cti [$];
    logic [3:0]  q_sel [$];
    logic        q_we  [$];
    logic [31:0] q_dat [$];
    logic [31:0] q_rd  [$];
    bit          done_seen, done_err, cyc_seen, prev_stall;
    int          acc_cyc, done_cyc, stb_cycles, stall_cycles, hold_viol;
    logic [15:0] prev_adr;
    logic [2:0]  prev_cti;

    always @(negedge clk) begin
        cyc_n++;
        if (clr_req != clr_ack) begin
            clr_ack = clr_req;
            q_adr.delete(); q_cti.delete(); q_sel.delete(); q_we.delete();
            q_dat.delete(); q_rd.delete();
            done_seen = 0; done_err = 0; cyc_seen = 0; prev_stall = 0;
            acc_cyc = -1; done_cyc = -1; stb_cycles = 0; stall_cycles = 0; hold_viol = 0;
        end
        if (!rst) begin
            if (cmd_valid & cmd_ready) acc_cyc = cyc_n;
            if (wb_cyc_o) begin
                cyc_seen = 1;
                if (prev_stall && (wb_adr_o !== prev_adr || wb_cti_o !== prev_cti)) hold_viol++;
                if (wb_stb_o) stb_cycles++;
                else stall_cycles++;
            end
            if (wb_cyc_o & wb_stb_o & wb_ack_i) begin
                q_adr.push_back(wb_adr_o); q_cti.push_back(wb_cti_o);
                q_sel.push_back(wb_sel_o); q_we.push_back(wb_we_o);
                q_dat.push_back(wb_dat_o);
            end
            if (rd_valid) q_rd.push_back(rd_data);
            if (done) begin done_seen = 1; done_err = err; done_cyc = cyc_n; end
            prev_stall = wb_cyc_o & !wb_stb_o;
            prev_adr   = wb_adr_o;
            prev_cti   = wb_cti_o;
        end
    end

    int total = 0;
    int bad   = 0;
    int last_stalls = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference address rule: next word inside a window of span bytes (whole space for linear).
    function automatic logic [15:0] nxt(input logic [15:0] a, input logic [1:0] bte);
        int span, ai;
        ai   = int'(a);
        span = (bte == 2'd0) ? 65536 : (8 << bte);
        return 16'((ai - ai % span) + ((ai % span) + 4) % span);
    endfunction

    function automatic int wsize(input logic [1:0] bte);
        return 2 << bte;
    endfunction

    task automatic check_zero(input string t);
        chk({t, " cyc"}, 32'(wb_cyc_o), 0);   chk({t, " stb"}, 32'(wb_stb_o), 0);
        chk({t, " we"}, 32'(wb_we_o), 0);     chk({t, " rd_valid"}, 32'(rd_valid), 0);
        chk({t, " done"}, 32'(done), 0);      chk({t, " err"}, 32'(err), 0);
        chk({t, " adr"}, 32'(wb_adr_o), 0);   chk({t, " cti"}, 32'(wb_cti_o), 0);
        chk({t, " bte"}, 32'(wb_bte_o), 0);   chk({t, " sel"}, 32'(wb_sel_o), 0);
        chk({t, " dat_o"}, wb_dat_o, 0);      chk({t, " rd_data"}, rd_data, 0);
    endtask

    task automatic run_cmd(input bit we, input logic [15:0] adr, input int len,
                           input logic [1:0] bte, input logic [3:0] sel,
                           input int g1, input int g2, input int gap,
                           input int e_at, input bit na, input bit seqd, input string nm);
        logic [31:0] wdat [16];
        logic [31:0] exp_rd [$];
        logic [15:0] a;
        bit          valid, hs;
        int          nexp, k, fb, wb, gap_left;
        for (int i = 0; i < 16; i++) wdat[i] = seqd ? 32'((i + 1) * 17) : $urandom;
        valid = (len >= 1 && len <= 16 && (bte == 2'd0 || len == wsize(bte)));
        clr_req++;
        err_at = e_at; nack = na;
        cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_len = 5'(len);
        cmd_bte = bte; cmd_sel = sel;
        @(negedge clk);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        fork
            begin
                k = 0; fb = 0;
                gap_left = (g1 == 0 || g2 == 0) ? gap : 0;
                if (we && valid) begin
                    while (k < len && !done_seen && fb < 3000) begin
                        wr_valid = (gap_left == 0);
                        wr_data  = wdat[k];
                        @(negedge clk);
                        hs = wr_valid && wr_ready;
                        @(posedge clk); #1;
                        if (gap_left > 0) gap_left--;
                        if (hs) begin
                            k++;
                            if (k == g1 || k == g2) gap_left = gap;
                        end
                        fb++;
                    end
                end
                wr_valid = 1'b0;
            end
            begin
                wb = 0;
                while (!done_seen && wb < 2000) begin @(negedge clk); wb++; end
            end
        join
        @(posedge clk); #1;

        chk({nm, " done"}, 32'(done_seen), 1);
        if (!valid) begin
            chk({nm, " reject err"}, 32'(done_err), 1);
            chk({nm, " reject cyc"}, 32'(cyc_seen), 0);
            chk({nm, " reject latency"}, 32'(done_cyc - acc_cyc), 1);
        end else begin
            nexp = na ? 0 : (e_at > 0 ? e_at - 1 : len);
            chk({nm, " err"}, 32'(done_err), 32'(na || e_at > 0));
            chk({nm, " beats"}, 32'(q_adr.size()), 32'(nexp));
            a = adr & 16'hfffc;
            for (int i = 0; i < nexp && i < q_adr.size(); i++) begin
                chk($sformatf("%s adr[%0d]", nm, i), 32'(q_adr[i]), 32'(a));
                chk($sformatf("%s cti[%0d]", nm, i), 32'(q_cti[i]),
                    32'(len == 1 ? 0 : (i == len - 1 ? 7 : 2)));
                chk($sformatf("%s sel[%0d]", nm, i), 32'(q_sel[i]), 32'(we ? sel : 4'hf));
                chk($sformatf("%s we[%0d]", nm, i), 32'(q_we[i]), 32'(we));
                if (we) begin
                    chk($sformatf("%s wdat[%0d]", nm, i), q_dat[i], wdat[i]);
                    for (int b = 0; b < 4; b++)
                        if (sel[b]) ref_mem[a[15:2]][8*b +: 8] = wdat[i][8*b +: 8];
                end else begin
                    exp_rd.push_back(ref_mem[a[15:2]]);
                end
                a = nxt(a, bte);
            end
            if (!we) begin
                chk({nm, " rd count"}, 32'(q_rd.size()), 32'(exp_rd.size()));
                for (int i = 0; i < q_rd.size() && i < exp_rd.size(); i++)
                    chk($sformatf("%s rd[%0d]", nm, i), q_rd[i], exp_rd[i]);
            end
            chk({nm, " stall hold"}, 32'(hold_viol), 0);
            if (na) chk({nm, " timeout stb cycles"}, 32'(stb_cycles), 255);
            if (len == 1 && !na && e_at == 0)
                chk({nm, " done latency"}, 32'(done_cyc - acc_cyc), 3);
        end
        last_stalls = stall_cycles;
        err_at = 0; nack = 1'b0;
        $display("txn %s we=%0d adr=%04h len=%0d bte=%0d beats=%0d err=%0d", nm, we, adr, len,
                 bte, q_adr.size(), done_err);
    endtask

    initial begin
        logic        rwe;
        logic [1:0]  rbte;
        logic [3:0]  rsel;
        int          rlen;
        for (int i = 0; i < 16384; i++) ref_mem[i] = mem_init(i);

        #12;
        check_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset cmd_ready", 32'(cmd_ready), 1);
        @(posedge clk); #1;

        run_cmd(0, 16'h0010, 1, 2'd0, 4'hf, -1, -1, 0, 0, 0, 0, "single_rd");
        run_cmd(1, 16'h0100, 8, 2'd0, 4'hf, -1, -1, 0, 0, 0, 1, "lin8_wr");
        run_cmd(0, 16'h0100, 8, 2'd0, 4'hf, -1, -1, 0, 0, 0, 0, "lin8_rdback");
        run_cmd(0, 16'h0038, 4, 2'd1, 4'hf, -1, -1, 0, 0, 0, 0, "wrap4_rd");
        run_cmd(0, 16'h0040, 0, 2'd0, 4'hf, -1, -1, 0, 0, 0, 0, "rej_len0");
        run_cmd(1, 16'h0040, 5, 2'd1, 4'hf, -1, -1, 0, 0, 0, 0, "rej_len5_wrap4");
        run_cmd(0, 16'h0040, 17, 2'd0, 4'hf, -1, -1, 0, 0, 0, 0, "rej_len17");
        run_cmd(0, 16'h0200, 8, 2'd0, 4'hf, -1, -1, 0, 3, 0, 0, "err_beat3");
        run_cmd(0, 16'h0300, 4, 2'd0, 4'hf, -1, -1, 0, 0, 1, 0, "timeout");
        run_cmd(1, 16'h0180, 8, 2'd0, 4'hf, 1, 4, 20, 0, 0, 0, "gap_wr");
        chk("gap_wr stalls seen", 32'(last_stalls >= 40), 1);
        run_cmd(1, 16'h0154, 8, 2'd2, 4'h5, -1, -1, 0, 0, 0, 0, "wrap8_wr");
        run_cmd(0, 16'h0150, 8, 2'd2, 4'hf, -1, -1, 0, 0, 0, 0, "wrap8_rd");
        run_cmd(0, 16'hfff8, 4, 2'd0, 4'hf, -1, -1, 0, 0, 0, 0, "lin_rollover");
        run_cmd(1, 16'h0128, 16, 2'd3, 4'hf, 2, -1, 3, 0, 0, 0, "wrap16_wr");
        run_cmd(0, 16'h013c, 16, 2'd3, 4'hf, -1, -1, 0, 0, 0, 0, "wrap16_rd");

        for (int n = 0; n < 24; n++) begin
            rwe  = 1'($urandom_range(0, 1));
            rbte = 2'($urandom_range(0, 3));
            rlen = (rbte == 2'd0) ? int'($urandom_range(1, 16)) : wsize(rbte);
            rsel = rwe ? 4'($urandom_range(1, 15)) : 4'hf;
            run_cmd(rwe, 16'h0400 + 16'($urandom_range(0, 63) * 4), rlen, rbte, rsel,
                    int'($urandom_range(0, 18)), int'($urandom_range(0, 18)),
                    int'($urandom_range(0, 6)), 0, 0, 0, $sformatf("rnd%0d", n));
        end

        // Asynchronous reset in the middle of a write burst.
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 16'h0800; cmd_len = 5'd8;
        cmd_bte = 2'd0; cmd_sel = 4'hf;
        @(negedge clk);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wr_valid = 1'b1; wr_data = 32'hcafe_0001;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_mid cyc before", 32'(wb_cyc_o), 1);
        #2 rst = 1'b1;
        #1 check_zero("rst_mid");
        wr_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid cmd_ready after", 32'(cmd_ready), 1);
        chk("rst_mid cyc after", 32'(wb_cyc_o), 0);
        $display("txn rst_mid asynchronous reset during write burst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
